audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_dac_serializer.sv | 136 +++++++++++++
 tb/tb_audio_dac_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// I2S / left-justified 16-bit stereo DAC serializer with a one-entry sample holding register.
// Bit clock is derived from CLOCK_50; data and word select change on bit-clock falling edges.
module audio_dac_serializer #(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned I2S_MODE  = 1
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        enable,
    input  logic [15:0] sample_L,
    input  logic [15:0] sample_R,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        underrun
);

    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic        r_bclk;
    logic        r_lrck;
    logic        r_dat;
    logic        r_underrun;
    logic        r_hold_full;
    logic [15:0] r_hold_L;
    logic [15:0] r_hold_R;
    logic [15:0] r_act_L;
    logic [15:0] r_act_R;

    logic        w_div_wrap;
    logic        w_fall;
    logic        w_frame_load;
    logic        w_xfer;
    logic [4:0]  w_slot;
    logic [3:0]  w_idx;
    logic [15:0] w_next_L;
    logic [15:0] w_next_R;
    logic        w_next_dat;

    assign w_div_wrap   = (r_div_cnt == 8'(BCLK_HALF - 1));
    assign w_fall       = enable & w_div_wrap & r_bclk;
    assign w_slot       = r_bit_cnt + 5'd1;
    assign w_frame_load = w_fall & (r_bit_cnt == 5'd31);
    assign w_xfer       = sample_valid & ~r_hold_full;

    assign w_next_L = (w_frame_load & r_hold_full) ? r_hold_L : r_act_L;
    assign w_next_R = (w_frame_load & r_hold_full) ? r_hold_R : r_act_R;

    // Bit index within the 16-bit word: I2S uses 16-s / 32-s (== -s mod 16),
    // left-justified uses 15-s / 31-s (== ~s mod 16).
    always_comb begin
        w_next_dat = 1'b0;
        w_idx      = '0;
        if (I2S_MODE != 0) begin
            w_idx = 4'd0 - w_slot[3:0];
            if (w_slot == 5'd0) begin
                // Pre-load active R still holds the previous frame's LSB.
                w_next_dat = r_act_R[0];
            end else if (w_slot <= 5'd16) begin
                w_next_dat = w_next_L[w_idx];
            end else begin
                w_next_dat = w_next_R[w_idx];
            end
        end else begin
            w_idx = ~w_slot[3:0];
            if (w_slot[4]) begin
                w_next_dat = w_next_R[w_idx];
            end else begin
                w_next_dat = w_next_L[w_idx];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_underrun <= 1'b0;
            r_act_L    <= '0;
            r_act_R    <= '0;
        end else if (!enable) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_underrun <= 1'b0;
            r_act_L    <= '0;
            r_act_R    <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_slot;
                r_lrck    <= w_slot[4];
                r_dat     <= w_next_dat;
            end
            if (w_frame_load) begin
                r_act_L    <= w_next_L;
                r_act_R    <= w_next_R;
                r_underrun <= ~r_hold_full;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_hold_full <= 1'b0;
            r_hold_L    <= '0;
            r_hold_R    <= '0;
        end else if (w_frame_load & r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_xfer) begin
            r_hold_full <= 1'b1;
            r_hold_L    <= sample_L;
            r_hold_R    <= sample_R;
        end
    end

    assign sample_ready = ~r_hold_full;
    assign AUD_BCLK     = r_bclk;
    assign AUD_DACLRCK  = r_lrck;
    assign AUD_DACDAT   = r_dat;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: an I2S instance (default divider) and a left-justified
// instance (minimum divider) checked every cycle against a time-based frame model.
module tb_audio_dac_serializer;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        enable = 1'b0;
    logic        valid  = 1'b0;
    logic [15:0] sL     = '0;
    logic [15:0] sR     = '0;
    logic [1:0]  rdy, bclk, lrck, dat, und;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_dac_serializer #(.BCLK_HALF(16), .I2S_MODE(1)) u_i2s (
        .CLOCK_50(clk), .Reset(rst), .enable(enable),
        .sample_L(sL), .sample_R(sR), .sample_valid(valid), .sample_ready(rdy[0]),
        .AUD_BCLK(bclk[0]), .AUD_DACLRCK(lrck[0]), .AUD_DACDAT(dat[0]), .underrun(und[0])
    );

    audio_dac_serializer #(.BCLK_HALF(2), .I2S_MODE(0)) u_lj (
        .CLOCK_50(clk), .Reset(rst), .enable(enable),
        .sample_L(sL), .sample_R(sR), .sample_valid(valid), .sample_ready(rdy[1]),
        .AUD_BCLK(bclk[1]), .AUD_DACLRCK(lrck[1]), .AUD_DACDAT(dat[1]), .underrun(und[1])
    );

    // Model: mk = enabled cycles since start; everything else follows from it arithmetically.
    int unsigned mk [2];
    logic        m_full [2];
    logic [15:0] m_hl [2], m_hr [2], m_l [2], m_r [2];
    logic        m_r0 [2], m_und [2];

    function automatic int unsigned bh_of(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    function automatic logic is_load(input int i);
        return enable && (((mk[i] + 1) % (64 * bh_of(i))) == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mk[i] <= 0; m_full[i] <= 1'b0; m_hl[i] <= '0; m_hr[i] <= '0;
                m_l[i] <= '0; m_r[i] <= '0; m_r0[i] <= 1'b0; m_und[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!enable) begin
                    mk[i] <= 0; m_l[i] <= '0; m_r[i] <= '0; m_r0[i] <= 1'b0; m_und[i] <= 1'b0;
                end else begin
                    mk[i] <= mk[i] + 1;
                    m_und[i] <= is_load(i) && !m_full[i];
                    if (is_load(i)) begin
                        m_r0[i] <= m_r[i][0];
                        if (m_full[i]) begin
                            m_l[i] <= m_hl[i];
                            m_r[i] <= m_hr[i];
                        end
                    end
                end
                if (is_load(i) && m_full[i]) begin
                    m_full[i] <= 1'b0;
                end else if (valid && !m_full[i]) begin
                    m_full[i] <= 1'b1;
                    m_hl[i]   <= sL;
                    m_hr[i]   <= sR;
                end
            end
        end
    end

    function automatic logic [4:0] model_out(input int i);
        int unsigned bh, slot;
        logic [15:0] lw, rw;
        logic d;
        bh   = bh_of(i);
        slot = (mk[i] / (2 * bh)) % 32;
        lw   = m_l[i];
        rw   = m_r[i];
        if (i == 0) begin
            if (slot == 0)       d = m_r0[i];
            else if (slot <= 16) d = lw[16 - slot];
            else                 d = rw[32 - slot];
        end else begin
            d = (slot < 16) ? lw[15 - slot] : rw[31 - slot];
        end
        return {1'((mk[i] / bh) % 2), (slot >= 16), d, m_und[i], !m_full[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Capture of serial slots per detected bit-clock fall.
    int unsigned fc [2];
    logic        prv_b [2];
    logic        prv_lr;
    int unsigned n_und [2];
    int unsigned first_fall [2];
    int unsigned rise_cyc [2];
    int unsigned lr_cyc [2];
    int unsigned n_rise, n_lrr;
    logic        cap_d  [2][4][32];
    logic        cap_lr [2][4][32];

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("outputs%0d{bclk,lrck,dat,und,rdy}", i),
                      32'({bclk[i], lrck[i], dat[i], und[i], rdy[i]}), 32'(model_out(i)));
                if (rst || !enable) begin
                    fc[i] = 0; prv_b[i] = 1'b0; n_und[i] = 0; first_fall[i] = 0;
                    for (int f = 0; f < 4; f++)
                        for (int s = 0; s < 32; s++) begin
                            cap_d[i][f][s] = 1'b0; cap_lr[i][f][s] = 1'b0;
                        end
                    if (i == 0) begin n_rise = 0; n_lrr = 0; prv_lr = 1'b0; end
                end else begin
                    if (und[i]) n_und[i]++;
                    if (prv_b[i] && !bclk[i]) begin
                        fc[i]++;
                        if (fc[i] == 1) first_fall[i] = cyc;
                        if (fc[i] < 128) begin
                            cap_d[i][fc[i] / 32][fc[i] % 32]  = dat[i];
                            cap_lr[i][fc[i] / 32][fc[i] % 32] = lrck[i];
                        end
                    end
                    if (i == 0) begin
                        if (!prv_b[0] && bclk[0] && n_rise < 2) begin rise_cyc[n_rise] = cyc; n_rise++; end
                        if (!prv_lr && lrck[0] && n_lrr < 2) begin lr_cyc[n_lrr] = cyc; n_lrr++; end
                        prv_lr = lrck[0];
                    end
                    prv_b[i] = bclk[i];
                end
            end
        end
    end

    function automatic logic [31:0] frame_bits(input int i, input int f, input int lo, input int hi);
        logic [31:0] v = '0;
        for (int s = lo; s <= hi; s++) v = {v[30:0], cap_d[i][f][s]};
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int unsigned rel;

    initial begin
        step(); step();
        check("reset_state_i2s", 32'({bclk[0], lrck[0], dat[0], und[0], rdy[0]}), 32'b00001);
        check("reset_state_lj",  32'({bclk[1], lrck[1], dat[1], und[1], rdy[1]}), 32'b00001);

        // One pair, then starve the holding register.
        enable = 1'b1; valid = 1'b1; sL = 16'hA5C3; sR = 16'h0F01;
        rst = 1'b0; rel = cyc;
        step();
        valid = 1'b0;
        for (int n = 0; n < 6000 && fc[0] < 97; n++) step();
        check("wait_directed_frames", 32'(fc[0] >= 97), 32'd1);
        check("bclk_period",     rise_cyc[1] - rise_cyc[0], 32'd32);
        check("bclk_high_time",  first_fall[0] - rise_cyc[0], 32'd16);
        check("first_fall_i2s",  first_fall[0] - rel, 32'd32);
        check("first_fall_lj",   first_fall[1] - rel, 32'd4);
        check("lrck_period",     lr_cyc[1] - lr_cyc[0], 32'd1024);
        check("i2s_frame0_zero", frame_bits(0, 0, 1, 31), 32'h0);
        check("i2s_f1_left",     frame_bits(0, 1, 1, 16), 32'h0000A5C3);
        check("i2s_f1_right",    frame_bits(0, 1, 17, 31), 32'h00000780);
        check("i2s_f2_slot0",    32'(cap_d[0][2][0]), 32'd1);
        check("i2s_f2_left",     frame_bits(0, 2, 1, 16), 32'h0000A5C3);
        check("i2s_f2_right",    frame_bits(0, 2, 17, 31), 32'h00000780);
        check("i2s_f3_slot0",    32'(cap_d[0][3][0]), 32'd1);
        check("i2s_lrck_edges",  32'({cap_lr[0][1][15], cap_lr[0][1][16], cap_lr[0][1][31], cap_lr[0][2][0]}), 32'b0110);
        check("i2s_underruns",   n_und[0], 32'd2);
        check("lj_f1_left",      frame_bits(1, 1, 0, 15), 32'h0000A5C3);
        check("lj_f1_right",     frame_bits(1, 1, 16, 31), 32'h00000F01);
        check("lj_f2_left",      frame_bits(1, 2, 0, 15), 32'h0000A5C3);
        check("lj_f2_right",     frame_bits(1, 2, 16, 31), 32'h00000F01);
        check("lj_lrck_edges",   32'({cap_lr[1][1][15], cap_lr[1][1][16]}), 32'b01);

        // Randomized traffic: streaming, sparse and starved segments, occasional disable.
        for (int seg = 0; seg < 8; seg++) begin
            int unsigned mode, len;
            mode = (seg == 0) ? 0 : $urandom_range(0, 2);
            len  = $urandom_range(600, 1500);
            if (seg == 3 || $urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(3, 40)) begin
                    valid = $urandom_range(0, 1) == 1; sL = 16'($urandom); sR = 16'($urandom);
                    step();
                end
            end
            enable = 1'b1;
            for (int c = 0; c < len; c++) begin
                valid = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
                sL = 16'($urandom);
                sR = 16'($urandom);
                step();
            end
        end

        // Reset in slot 20 with a pair held: the pair must be lost.
        enable = 1'b1; valid = 1'b0;
        for (int n = 0; n < 3000 && !(fc[0] % 32 == 19 && fc[0] > 0); n++) step();
        check("wait_slot19", 32'(fc[0] % 32), 32'd19);
        valid = 1'b1; sL = 16'h1234; sR = 16'h5678;
        step();
        valid = 1'b0;
        for (int n = 0; n < 100 && (fc[0] % 32) != 20; n++) step();
        check("wait_slot20", 32'(fc[0] % 32), 32'd20);
        check("held_before_reset", 32'(rdy[0]), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("async_reset_i2s", 32'({bclk[0], lrck[0], dat[0], und[0], rdy[0]}), 32'b00001);
        check("async_reset_lj",  32'({bclk[1], lrck[1], dat[1], und[1], rdy[1]}), 32'b00001);
        step(); step();
        rst = 1'b0; rel = cyc;
        for (int n = 0; n < 3000 && fc[0] < 65; n++) step();
        check("wait_after_reset",   32'(fc[0] >= 65), 32'd1);
        check("restart_first_fall", first_fall[0] - rel, 32'd32);
        check("restart_f0_zero",    frame_bits(0, 0, 1, 31), 32'h0);
        check("restart_f1_zero",    frame_bits(0, 1, 0, 31), 32'h0);
        check("restart_underruns",  n_und[0], 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
